// File: rtl/nnoc_sched_pkg.sv
// Shared types for the systolic tile scheduler: int8 element, 4x4 tile, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nnoc_sched_pkg;

  localparam int ARRAY_N = 4;

  typedef logic [7:0] int8_t;

  // Row-major tile: row r occupies elements 4r..4r+3.
  typedef int8_t [ARRAY_N*ARRAY_N-1:0] tile_act_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_DRAIN,
    ST_RESULT
  } sched_state_e;

endpackage

// File: rtl/systolic_tile_sched_if.sv
// Tile handshake, shift-buffer load, PE control and result hand-off bundle.
// Latency: n/a (wires only).
// Backpressure: tile_valid/tile_ready on ingress, res_valid/res_ready on result.
interface systolic_tile_sched_if;
  import nnoc_sched_pkg::*;

  logic       tile_valid;
  logic       tile_ready;
  tile_act_t  tile_act;
  logic       tile_first;
  logic       tile_last;
  logic       sb_load;
  tile_act_t  sb_act;
  logic       pe_en;
  logic       acc_clr;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] tile_cnt;
  logic       busy;

  // Tile source / result sink side.
  modport master (
    output tile_valid, tile_act, tile_first, tile_last, res_ready,
    input  tile_ready, sb_load, sb_act, pe_en, acc_clr, res_valid, tile_cnt, busy
  );

  // Scheduler side.
  modport slave (
    input  tile_valid, tile_act, tile_first, tile_last, res_ready,
    output tile_ready, sb_load, sb_act, pe_en, acc_clr, res_valid, tile_cnt, busy
  );

endinterface

// File: rtl/systolic_tile_sched.sv
// Sequences one 4x4 int8 tile: shift-buffer load, skewed stream, drain, K-split result hand-off.
// Latency: sb_load at accept+1, pe_en accept+2..accept+8+DRAIN_CYCLES, res_valid at accept+9+DRAIN_CYCLES.
// Backpressure: tile_ready only in IDLE; res_valid held in RESULT until res_ready.
module systolic_tile_sched
  import nnoc_sched_pkg::*;
#(
  parameter int N            = 4,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  systolic_tile_sched_if.slave  bus
);

  localparam int STREAM_CYCLES = 2*N - 1;
  localparam int MAX_PHASE     = (STREAM_CYCLES > DRAIN_CYCLES) ? STREAM_CYCLES : DRAIN_CYCLES;
  localparam int CW            = $clog2(MAX_PHASE);

  localparam logic [CW-1:0] STREAM_LAST = CW'(STREAM_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LAST  = CW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  sched_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  tile_act_t     sb_act_q, sb_act_d;
  logic          first_q, first_d;
  logic          last_q, last_d;
  logic [7:0]    tile_cnt_q, tile_cnt_d;

  logic          idle_ready;
  logic          sb_load;
  logic          pe_en;
  logic          acc_clr;
  logic          res_valid;
  logic          open_first;

  // A tile with no open group behind it must start a fresh accumulation.
  assign open_first = first_q || (tile_cnt_q == 8'd0);

  // State register, phase counter and captured tile context.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sb_act_q   <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      tile_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sb_act_q   <= sb_act_d;
      first_q    <= first_d;
      last_q     <= last_d;
      tile_cnt_q <= tile_cnt_d;
    end
  end

  // Next-state and Moore output decode from the registered state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sb_act_d   = sb_act_q;
    first_d    = first_q;
    last_d     = last_q;
    tile_cnt_d = tile_cnt_q;
    idle_ready = 1'b0;
    sb_load    = 1'b0;
    pe_en      = 1'b0;
    acc_clr    = 1'b0;
    res_valid  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        idle_ready = 1'b1;
        if (bus.tile_valid) begin
          sb_act_d = bus.tile_act;
          first_d  = bus.tile_first;
          last_d   = bus.tile_last;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        sb_load = 1'b1;
        acc_clr = open_first;
        if (open_first) begin
          tile_cnt_d = 8'd1;
        end else if (tile_cnt_q != 8'hFF) begin
          tile_cnt_d = tile_cnt_q + 8'd1;
        end
        cnt_d   = STREAM_LAST;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        pe_en = 1'b1;
        if (cnt_q == '0) begin
          if (DRAIN_CYCLES > 0) begin
            cnt_d   = DRAIN_LAST;
            state_d = ST_DRAIN;
          end else begin
            state_d = last_q ? ST_RESULT : ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DRAIN: begin
        pe_en = 1'b1;
        if (cnt_q == '0) begin
          state_d = last_q ? ST_RESULT : ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RESULT: begin
        res_valid = 1'b1;
        if (bus.res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Ready is masked while reset is held so nothing looks acceptable during reset.
  assign bus.tile_ready = idle_ready && reset;
  assign bus.sb_load    = sb_load;
  assign bus.sb_act     = sb_act_q;
  assign bus.pe_en      = pe_en;
  assign bus.acc_clr    = acc_clr;
  assign bus.res_valid  = res_valid;
  assign bus.tile_cnt   = tile_cnt_q;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule
